lif_spike_event_fifo: RTL and testbench

//  Downstream stage of the LIF neuron system: turns spike_out pulses into timestamped

---
 rtl/lif_spike_event_fifo_if.sv | 29 ++
 rtl/lif_spike_event_fifo.sv | 113 +++++++++++
 tb/tb_lif_spike_event_fifo.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_spike_event_fifo_if.sv
// Spike event readout interface.
// Carries the head-of-queue event from the event FIFO to a host or next-layer block.
//   ev_valid : head event is available (producer -> consumer)
//   ev_ready : consumer accepts the head event (consumer -> producer)
//   ev_ts    : timestamp of the head event
//   ev_vmem  : membrane snapshot of the head event
interface lif_spike_event_fifo_if #(
   parameter int TS_W = 8,
   parameter int VM_W = 7
);
   logic            ev_valid;
   logic            ev_ready;
   logic [TS_W-1:0] ev_ts;
   logic [VM_W-1:0] ev_vmem;

   modport master (
      output ev_valid,
      output ev_ts,
      output ev_vmem,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_ts,
      input  ev_vmem,
      output ev_ready
   );
endinterface

// File: rtl/lif_spike_event_fifo.sv
// LIF spike event FIFO.
// Turns rising edges of the neuron spike output into timestamped events
// {ts, v_mem snapshot} and queues them for readout over a valid/ready handshake.
// Events that arrive while the queue is full are dropped and recorded in a sticky
// overflow flag and a saturating drop counter.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : gates the timestamp counter and spike capture
//   spike_in   : neuron spike output
//   v_mem_in   : neuron membrane value, sampled on capture
//   clr_ovf    : synchronous clear of overflow and drop_count
//   ev         : event readout handshake (master side)
//   level      : current occupancy, 0..DEPTH
//   overflow   : sticky, at least one event was dropped
//   drop_count : dropped events, saturating at 255
module lif_spike_event_fifo #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 8,
   parameter int VM_W  = 7
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     spike_in,
   input  logic [VM_W-1:0]          v_mem_in,
   input  logic                     clr_ovf,
   lif_spike_event_fifo_if.master   ev,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = TS_W + VM_W;

   logic [TS_W-1:0] ts;
   logic            spike_d;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [EW-1:0]   mem [DEPTH];
   logic [EW-1:0]   head;

   logic push_req;
   logic pop;
   logic push_ok;
   logic drop;
   logic empty;
   logic full;

   function automatic logic [7:0] sat_inc8(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign push_req = enable & spike_in & ~spike_d;
   assign pop      = ~empty & ev.ev_ready;
   // A full queue still takes a new event when the head leaves in the same cycle.
   assign push_ok  = push_req & (~full | pop);
   assign drop     = push_req & ~push_ok;

   assign level       = wr_ptr - rd_ptr;
   assign head        = mem[rd_ptr[AW-1:0]];
   assign ev.ev_valid = ~empty;
   // Storage is not reset; masking keeps the head outputs at zero while nothing is queued.
   assign ev.ev_ts    = empty ? '0 : head[EW-1:VM_W];
   assign ev.ev_vmem  = empty ? '0 : head[VM_W-1:0];

   // Capture stage: timestamp counter and spike edge detector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts      <= '0;
         spike_d <= 1'b0;
      end else if (enable) begin
         ts      <= ts + TS_W'(1);
         spike_d <= spike_in;
      end
   end

   // Queue pointers; the extra MSB separates full from empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Event storage; the word uses ts before this cycle's increment.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= {ts, v_mem_in};
   end

   // Drop bookkeeping; a drop in the same cycle as clr_ovf takes priority.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else if (drop) begin
         overflow   <= 1'b1;
         drop_count <= clr_ovf ? 8'd1 : sat_inc8(drop_count);
      end else if (clr_ovf) begin
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end
   end

endmodule

// File: tb/tb_lif_spike_event_fifo.sv
// Directed bench for the spike event FIFO: a queue-based event model checked
// against the DUT on every falling edge, plus hand-computed literal expectations.
module tb_lif_spike_event_fifo;

   localparam int DEPTH = 8;
   localparam int TS_W  = 8;
   localparam int VM_W  = 7;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            enable;
   logic            spike_in;
   logic [VM_W-1:0] v_mem_in;
   logic            clr_ovf;
   logic [3:0]      level;
   logic            overflow;
   logic [7:0]      drop_count;

   int checks   = 0;
   int failures = 0;

   lif_spike_event_fifo_if #(.TS_W(TS_W), .VM_W(VM_W)) ev_if ();

   lif_spike_event_fifo #(.DEPTH(DEPTH), .TS_W(TS_W), .VM_W(VM_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .spike_in   (spike_in),
      .v_mem_in   (v_mem_in),
      .clr_ovf    (clr_ovf),
      .ev         (ev_if),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int              m_ts;
   bit              m_spike_prev;
   bit [14:0]       m_q[$];
   bit              m_ovf;
   int              m_drops;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ts = 0;
         m_spike_prev = 0;
         m_q.delete();
         m_ovf = 0;
         m_drops = 0;
      end else begin
         bit rise;
         bit popped;
         rise   = enable && spike_in && !m_spike_prev;
         popped = (m_q.size() != 0) && ev_if.ev_ready;
         if (popped) void'(m_q.pop_front());
         if (rise) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back({m_ts[7:0], v_mem_in});
            end else begin
               m_ovf = 1;
               m_drops = clr_ovf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end
         end else if (clr_ovf) begin
            m_ovf = 0;
            m_drops = 0;
         end
         if (enable) begin
            m_ts = (m_ts + 1) % 256;
            m_spike_prev = spike_in;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: DUT against model on every falling edge.
   always @(negedge clk) begin
      chk("m_valid", 32'(ev_if.ev_valid), 32'(m_q.size() != 0));
      chk("m_level", 32'(level), 32'(m_q.size()));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_drop_count", 32'(drop_count), 32'(m_drops));
      if (m_q.size() != 0) begin
         chk("m_ev_ts", 32'(ev_if.ev_ts), 32'(m_q[0][14:7]));
         chk("m_ev_vmem", 32'(ev_if.ev_vmem), 32'(m_q[0][6:0]));
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_ts[8] = '{9, 11, 13, 15, 17, 19, 21, 28};
      reset_n = 1'b0;
      enable = 1'b0;
      spike_in = 1'b0;
      v_mem_in = '0;
      clr_ovf = 1'b0;
      ev_if.ev_ready = 1'b0;
      cycles(3);
      chk("rst_level", 32'(level), 0);
      chk("rst_valid", 32'(ev_if.ev_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_drop", 32'(drop_count), 0);

      // Single event from a spike held four cycles at ts=10
      reset_n = 1'b1;
      enable = 1'b1;
      cycles(10);
      spike_in = 1'b1;
      v_mem_in = 7'h3F;
      cycles(4);
      spike_in = 1'b0;
      chk("t2_level", 32'(level), 1);
      chk("t2_ts", 32'(ev_if.ev_ts), 10);
      chk("t2_vmem", 32'(ev_if.ev_vmem), 32'h3F);

      // Asynchronous reset mid-stream
      #2 reset_n = 1'b0;
      #1;
      chk("t1_valid", 32'(ev_if.ev_valid), 0);
      chk("t1_level", 32'(level), 0);
      chk("t1_ts", 32'(ev_if.ev_ts), 0);
      chk("t1_vmem", 32'(ev_if.ev_vmem), 0);
      cycles(1);
      reset_n = 1'b1;
      cycles(5);
      spike_in = 1'b1;
      v_mem_in = 7'h12;
      cycles(1);
      spike_in = 1'b0;
      chk("t1_ts5", 32'(ev_if.ev_ts), 5);
      chk("t1_vmem5", 32'(ev_if.ev_vmem), 32'h12);
      ev_if.ev_ready = 1'b1;
      cycles(1);
      ev_if.ev_ready = 1'b0;
      chk("t1_empty", 32'(level), 0);

      // Ten isolated spikes, no readout: ts 7,9,...,25
      for (int i = 0; i < 10; i++) begin
         spike_in = 1'b1;
         v_mem_in = 7'(i);
         cycles(1);
         spike_in = 1'b0;
         cycles(1);
      end
      chk("t3_level", 32'(level), 8);
      chk("t3_overflow", 32'(overflow), 1);
      chk("t3_drop", 32'(drop_count), 2);
      chk("t3_head", 32'(ev_if.ev_ts), 7);
      clr_ovf = 1'b1;
      cycles(1);
      clr_ovf = 1'b0;
      chk("t3_clr_ovf", 32'(overflow), 0);
      chk("t3_clr_drop", 32'(drop_count), 0);
      chk("t3_clr_level", 32'(level), 8);

      // Full queue, push and pop together at ts=28
      spike_in = 1'b1;
      v_mem_in = 7'h55;
      ev_if.ev_ready = 1'b1;
      cycles(1);
      spike_in = 1'b0;
      ev_if.ev_ready = 1'b0;
      chk("t4_level", 32'(level), 8);
      chk("t4_overflow", 32'(overflow), 0);
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t4_drain_ts", 32'(ev_if.ev_ts), 32'(exp_ts[i]));
         if (i == 7) chk("t4_last_vmem", 32'(ev_if.ev_vmem), 32'h55);
         cycles(1);
      end
      ev_if.ev_ready = 1'b0;
      chk("t4_empty", 32'(ev_if.ev_valid), 0);

      // Timestamp wrap: ts is 37 here
      cycles(217);
      spike_in = 1'b1;
      v_mem_in = 7'd1;
      cycles(1);
      spike_in = 1'b0;
      cycles(2);
      spike_in = 1'b1;
      v_mem_in = 7'd2;
      cycles(1);
      spike_in = 1'b0;
      chk("t5_level", 32'(level), 2);
      chk("t5_ts254", 32'(ev_if.ev_ts), 254);
      ev_if.ev_ready = 1'b1;
      cycles(1);
      chk("t5_ts1", 32'(ev_if.ev_ts), 1);
      cycles(1);
      ev_if.ev_ready = 1'b0;
      chk("t5_empty", 32'(level), 0);

      // Eight stored plus 300 dropped events
      for (int i = 0; i < 308; i++) begin
         spike_in = 1'b1;
         v_mem_in = 7'(i);
         cycles(1);
         spike_in = 1'b0;
         cycles(1);
      end
      chk("t6_level", 32'(level), 8);
      chk("t6_overflow", 32'(overflow), 1);
      chk("t6_drop_sat", 32'(drop_count), 255);
      clr_ovf = 1'b1;
      cycles(1);
      clr_ovf = 1'b0;
      chk("t6_clr_ovf", 32'(overflow), 0);
      chk("t6_clr_drop", 32'(drop_count), 0);
      chk("t6_clr_level", 32'(level), 8);

      // Drop and clear in the same cycle
      spike_in = 1'b1;
      clr_ovf = 1'b1;
      cycles(1);
      spike_in = 1'b0;
      clr_ovf = 1'b0;
      chk("t6_both_ovf", 32'(overflow), 1);
      chk("t6_both_drop", 32'(drop_count), 1);

      // Readout with enable low
      enable = 1'b0;
      ev_if.ev_ready = 1'b1;
      cycles(8);
      ev_if.ev_ready = 1'b0;
      chk("rd_dis_level", 32'(level), 0);
      chk("rd_dis_valid", 32'(ev_if.ev_valid), 0);

      cycles(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
